// File: rtl/power_pkg.sv
// power_pkg: constants shared by the power pipeline and its bench.
//   MODE_SQUARE / MODE_CUBE : encoding of the per-operand mode bit
//   DEFAULT_W / DEFAULT_TAG_W : default operand and tag widths
package power_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_CUBE   = 1'b1;

  localparam int DEFAULT_W     = 8;
  localparam int DEFAULT_TAG_W = 4;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage made of a valid bit plus a payload.
//   clk, rst   : clock and asynchronous active-high reset (clears everything)
//   en         : stage loads from its predecessor on this edge
//   valid_in   : predecessor valid bit
//   data_in    : predecessor payload (PW bits)
//   valid_out  : registered valid bit
//   data_out   : registered payload
module pipe_stage_reg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_in,
  input  logic [PW-1:0] data_in,
  output logic          valid_out,
  output logic [PW-1:0] data_out
);

  logic          valid_d, valid_q;
  logic [PW-1:0] data_d, data_q;

  // A bubble still advances (valid drops), but the payload is only captured
  // for a real operand so unaccepted input data never enters the pipe.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = valid_in;
      if (valid_in) begin
        data_d = data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/power_pipeline.sv
// power_pipeline: three-stage pipeline returning x^2 or x^3 with a sideband tag.
//   clk, rst                        : clock, asynchronous active-high reset
//   in_valid/in_ready               : input handshake
//   in_data (W), in_mode, in_tag    : operand, 0=square 1=cube, opaque tag
//   out_valid/out_ready             : output handshake
//   out_data (3W), out_mode, out_tag: result with its own mode and tag
// Stages: S1 holds x, S2 holds x^2 and x, S3 holds the final result.
module power_pipeline
  import power_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3*W-1:0]   out_data,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S1_W = TAG_W + 1 + W;
  localparam int S2_W = TAG_W + 1 + W + 2*W;
  localparam int S3_W = TAG_W + 1 + 3*W;

  logic            adv;
  logic            s1_valid, s2_valid, s3_valid;
  logic [S1_W-1:0] s1_in, s1_out;
  logic [S2_W-1:0] s2_in, s2_out;
  logic [S3_W-1:0] s3_in, s3_out;

  logic [W-1:0]     s1_x, s2_x;
  logic             s1_mode, s2_mode;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [2*W-1:0]   s1_x_ext, s1_sq, s2_sq;
  logic [3*W-1:0]   s2_sq_ext, s2_x_ext, s2_cube, s2_result;

  // Whole pipe moves in lockstep: it stalls only when a result is being
  // presented and refused, so a freed output slot is refilled the same cycle.
  assign adv      = out_ready || !s3_valid;
  assign in_ready = adv;

  assign s1_in = {in_tag, in_mode, in_data};
  assign {s1_tag, s1_mode, s1_x} = s1_out;
  assign {s2_tag, s2_mode, s2_x, s2_sq} = s2_out;

  // Operands are widened before multiplying so the products are exact.
  always_comb begin
    s1_x_ext  = {{W{1'b0}}, s1_x};
    s1_sq     = s1_x_ext * s1_x_ext;
    s2_in     = {s1_tag, s1_mode, s1_x, s1_sq};
    s2_sq_ext = {{W{1'b0}}, s2_sq};
    s2_x_ext  = {{(2*W){1'b0}}, s2_x};
    s2_cube   = s2_sq_ext * s2_x_ext;
    s2_result = (s2_mode == MODE_CUBE) ? s2_cube : s2_sq_ext;
    s3_in     = {s2_tag, s2_mode, s2_result};
  end

  pipe_stage_reg #(.PW(S1_W)) u_s1 (
    .clk(clk), .rst(rst), .en(adv),
    .valid_in(in_valid), .data_in(s1_in),
    .valid_out(s1_valid), .data_out(s1_out)
  );

  pipe_stage_reg #(.PW(S2_W)) u_s2 (
    .clk(clk), .rst(rst), .en(adv),
    .valid_in(s1_valid), .data_in(s2_in),
    .valid_out(s2_valid), .data_out(s2_out)
  );

  pipe_stage_reg #(.PW(S3_W)) u_s3 (
    .clk(clk), .rst(rst), .en(adv),
    .valid_in(s2_valid), .data_in(s3_in),
    .valid_out(s3_valid), .data_out(s3_out)
  );

  assign out_valid = s3_valid;
  assign {out_tag, out_mode, out_data} = s3_out;

endmodule

// File: tb/tb_power_pipeline.sv
// tb_power_pipeline: directed self-checking bench for power_pipeline.
// Two instances: the default 8-bit build and a 12-bit build.
module tb_power_pipeline;
  import power_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_mode;
  logic [7:0]  in_data;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_mode;
  logic [23:0] out_data;
  logic [3:0]  out_tag;

  logic        w_in_valid, w_in_ready, w_in_mode;
  logic [11:0] w_in_data;
  logic [3:0]  w_in_tag;
  logic        w_out_valid, w_out_ready, w_out_mode;
  logic [35:0] w_out_data;
  logic [3:0]  w_out_tag;

  int compared   = 0;
  int mismatched = 0;

  int xs [6] = '{2, 3, 4, 5, 10, 255};
  int cs [6] = '{8, 27, 64, 125, 1000, 16581375};

  power_pipeline #(.W(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode), .out_tag(out_tag)
  );

  power_pipeline #(.W(12), .TAG_W(4)) dut_w12 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_mode(w_out_mode), .out_tag(w_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int x, input logic m,
                               input int t, input logic rdy);
    in_valid  = v;
    in_data   = x[7:0];
    in_mode   = m;
    in_tag    = t[3:0];
    out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
      $error("[TB] check %s did not agree", name);
    end
  endtask

  task automatic checkResult(input string name, input longint data,
                             input logic m, input int t);
    checkOutput({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({name, "_data"},  {40'd0, out_data}, data);
    checkOutput({name, "_mode"},  {63'd0, out_mode}, {63'd0, m});
    checkOutput({name, "_tag"},   {60'd0, out_tag}, t);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_data = 0; in_mode = 0; in_tag = 0; out_ready = 1;
    w_in_valid = 0; w_in_data = 0; w_in_mode = 0; w_in_tag = 0; w_out_ready = 1;
    tick();
    tick();

    // Reset state
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_data",  {40'd0, out_data}, 64'd0);
    checkOutput("rst_out_mode",  {63'd0, out_mode}, 64'd0);
    checkOutput("rst_out_tag",   {60'd0, out_tag}, 64'd0);
    checkOutput("rst_w12_valid", {63'd0, w_out_valid}, 64'd0);
    rst = 1'b0;

    // Back-to-back cube stream; first result three edges after acceptance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, xs[i], MODE_CUBE, i, 1'b1);
      tick();
      if (i >= 2)
        checkResult($sformatf("stream%0d", i - 2), cs[i-2], MODE_CUBE, i - 2);
      else
        checkOutput($sformatf("stream_fill%0d", i), {63'd0, out_valid}, 64'd0);
    end
    applyStimulus(1'b0, 0, MODE_SQUARE, 0, 1'b1);
    tick();
    checkResult("stream4", cs[4], MODE_CUBE, 4);
    tick();
    checkResult("stream5", cs[5], MODE_CUBE, 5);
    tick();
    checkOutput("stream_drained", {63'd0, out_valid}, 64'd0);

    // Interleaved modes on the same operand
    applyStimulus(1'b1, 7, MODE_SQUARE, 1, 1'b1);
    tick();
    applyStimulus(1'b1, 7, MODE_CUBE, 2, 1'b1);
    tick();
    applyStimulus(1'b0, 0, MODE_SQUARE, 0, 1'b1);
    tick();
    checkResult("mix_sq", 49, MODE_SQUARE, 1);
    tick();
    checkResult("mix_cube", 343, MODE_CUBE, 2);
    tick();
    checkOutput("mix_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: three in flight, a fourth offered while stalled
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, i, MODE_CUBE, i, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 4, MODE_CUBE, 4, 1'b0);
    checkOutput("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      checkResult($sformatf("bp_hold%0d", c), 1, MODE_CUBE, 1);
      checkOutput($sformatf("bp_stall_ready%0d", c), {63'd0, in_ready}, 64'd0);
      tick();
    end
    checkResult("bp_hold_end", 1, MODE_CUBE, 1);
    applyStimulus(1'b1, 4, MODE_CUBE, 4, 1'b1);
    checkOutput("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    applyStimulus(1'b0, 0, MODE_SQUARE, 0, 1'b1);
    checkResult("bp_r2", 8, MODE_CUBE, 2);
    tick();
    checkResult("bp_r3", 27, MODE_CUBE, 3);
    tick();
    checkResult("bp_r4", 64, MODE_CUBE, 4);
    tick();
    checkOutput("bp_drained", {63'd0, out_valid}, 64'd0);

    // Bubble in the middle of the stream must survive to the output
    applyStimulus(1'b1, 3, MODE_SQUARE, 8, 1'b1);
    tick();
    applyStimulus(1'b0, 170, MODE_CUBE, 15, 1'b1);
    tick();
    applyStimulus(1'b1, 6, MODE_SQUARE, 9, 1'b1);
    tick();
    applyStimulus(1'b0, 0, MODE_SQUARE, 0, 1'b1);
    checkResult("bub_first", 9, MODE_SQUARE, 8);
    tick();
    checkOutput("bub_gap", {63'd0, out_valid}, 64'd0);
    tick();
    checkResult("bub_second", 36, MODE_SQUARE, 9);
    tick();
    checkOutput("bub_drained", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream with a result on the output
    applyStimulus(1'b1, 9, MODE_CUBE, 5, 1'b1);
    tick();
    applyStimulus(1'b1, 8, MODE_CUBE, 6, 1'b1);
    tick();
    applyStimulus(1'b0, 0, MODE_SQUARE, 0, 1'b1);
    tick();
    checkResult("pre_rst", 729, MODE_CUBE, 5);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midrst_data",  {40'd0, out_data}, 64'd0);
    applyStimulus(1'b1, 77, MODE_CUBE, 3, 1'b1);
    tick();
    checkOutput("inrst_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 5, MODE_CUBE, 7, 1'b1);
    tick();
    applyStimulus(1'b0, 0, MODE_SQUARE, 0, 1'b1);
    checkOutput("postrst_stale1", {63'd0, out_valid}, 64'd0);
    tick();
    checkOutput("postrst_stale2", {63'd0, out_valid}, 64'd0);
    tick();
    checkResult("postrst_first", 125, MODE_CUBE, 7);
    tick();
    checkOutput("postrst_drained", {63'd0, out_valid}, 64'd0);

    // 12-bit build: largest cube and a zero square
    w_in_valid = 1'b1; w_in_data = 12'd4095; w_in_mode = MODE_CUBE; w_in_tag = 4'd10;
    tick();
    w_in_data = 12'd0; w_in_mode = MODE_SQUARE; w_in_tag = 4'd3;
    tick();
    w_in_valid = 1'b0;
    tick();
    checkOutput("w12_cube_valid", {63'd0, w_out_valid}, 64'd1);
    checkOutput("w12_cube_data",  {28'd0, w_out_data}, 64'd68669157375);
    checkOutput("w12_cube_tag",   {60'd0, w_out_tag}, 64'd10);
    tick();
    checkOutput("w12_zero_valid", {63'd0, w_out_valid}, 64'd1);
    checkOutput("w12_zero_data",  {28'd0, w_out_data}, 64'd0);
    checkOutput("w12_zero_mode",  {63'd0, w_out_mode}, 64'd0);
    tick();
    checkOutput("w12_drained", {63'd0, w_out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
